// File: rtl/regfile_xfer.sv
// ============================================================================
// Module   : regfile_xfer
// Brief    : Debug engine that dumps x0..x31 to a stream or loads them from one.
//            Optional load path is built only when REGFILE_XFER_LOAD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_xfer #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_last,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_dread = 3'd1;
    localparam logic [2:0] c_dsend = 3'd2;
    localparam logic [2:0] c_done  = 3'd4;
`ifdef REGFILE_XFER_LOAD_EN
    localparam logic [2:0] c_load  = 3'd3;
`endif
    localparam logic [4:0] c_last  = 5'(NREGS - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [4:0]      r_idx;
    logic            r_out_valid;
    logic            r_out_last;
    logic [XLEN-1:0] r_out_data;
    logic            r_we;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic            w_abort;

    assign w_abort = abort && (r_state != c_idle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (start && !abort) begin
                    if (!mode) begin
                        w_state_nxt = c_dread;
                    end
`ifdef REGFILE_XFER_LOAD_EN
                    else begin
                        w_state_nxt = c_load;
                    end
`endif
                end
            end
            c_dread: w_state_nxt = c_dsend;
            c_dsend: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = r_out_last ? c_done : c_dread;
                end
            end
`ifdef REGFILE_XFER_LOAD_EN
            c_load: begin
                if (in_valid && (r_idx == c_last)) begin
                    w_state_nxt = c_done;
                end
            end
`endif
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
        if (w_abort) begin
            w_state_nxt = c_idle;
        end
    end

    // Write strobe defaults low so it lasts exactly one cycle per acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= 5'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_we        <= 1'b0;
            r_waddr     <= 5'd0;
            r_wdata     <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_abort) begin
                r_idx       <= 5'd0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                case (r_state)
                    c_idle: r_idx <= 5'd0;
                    c_dread: begin
                        r_out_data  <= rf_rdata;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_idx == c_last);
                    end
                    c_dsend: begin
                        if (r_out_valid && out_ready) begin
                            r_out_valid <= 1'b0;
                            if (!r_out_last) begin
                                r_idx <= r_idx + 5'd1;
                            end
                        end
                    end
`ifdef REGFILE_XFER_LOAD_EN
                    c_load: begin
                        if (in_valid) begin
                            r_we    <= (r_idx != 5'd0);
                            r_waddr <= r_idx;
                            r_wdata <= in_data;
                            if (r_idx != c_last) begin
                                r_idx <= r_idx + 5'd1;
                            end
                        end
                    end
`endif
                    c_done: begin
                        r_idx      <= 5'd0;
                        r_out_last <= 1'b0;
                    end
                    default: r_idx <= 5'd0;
                endcase
            end
        end
    end

    assign busy      = (r_state != c_idle);
    assign done      = (r_state == c_done);
    assign rf_raddr  = ((r_state == c_dread) || (r_state == c_dsend)) ? r_idx : 5'd0;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_data  = r_out_data;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;

`ifdef REGFILE_XFER_LOAD_EN
    assign in_ready = (r_state == c_load);
    assign rf_we    = r_we;
`else
    logic w_unused;
    assign w_unused = ^{in_valid, in_data, r_we};
    assign in_ready = 1'b0;
    assign rf_we    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_xfer.sv
// ============================================================================
// Module   : tb_regfile_xfer
// Brief    : Directed bench for regfile_xfer with a behavioural 32x32 register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_xfer;

`ifdef REGFILE_XFER_LOAD_EN
    localparam logic c_load_en = 1'b1;
`else
    localparam logic c_load_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, mode, abort, busy, done;
    logic [4:0]  rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, rf_wdata, out_data, in_data;
    logic        rf_we, out_valid, out_ready, out_last, in_valid, in_ready;
    logic        preload;
    logic [31:0] regs [32];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    regfile_xfer #(.NREGS(32), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data)
    );

    assign rf_rdata = regs[rf_raddr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + i;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rf_we) chk("we_not_x0", {31'd0, rf_waddr != 5'd0}, 32'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_dump(input bit throttle, input logic [31:0] base);
        int n = 0;
        int ncyc = 0;
        bit got_done = 0;
        bit prev_stall = 0;
        bit last_hs = 0;
        logic [31:0] prev_data = '0;
        logic prev_last = 1'b0;
        start = 1; mode = 0; step(); start = 0;
        while (ncyc < 400 && !got_done) begin
            if (done) begin
                chk("done_after_last", {31'd0, last_hs}, 32'd1);
                got_done = 1;
            end else begin
                if (prev_stall) begin
                    chk("stall_data", out_data, prev_data);
                    chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
                end
                out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                last_hs = 0;
                if (out_valid && out_ready) begin
                    chk("dump_word", out_data, (n == 0) ? 32'h0 : base + n);
                    chk("dump_last", {31'd0, out_last}, {31'd0, n == 31});
                    last_hs = out_last;
                    n++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                step();
                ncyc++;
            end
        end
        if (!got_done) chk("dump_timeout", 32'd0, 32'd1);
        if (!throttle) chk("dump_cycles", ncyc, 32'd64);
        chk("dump_count", n, 32'd32);
        out_ready = 0;
        step();
        chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    task automatic run_load(input logic [31:0] base, input bit gapped, input int stop_after);
        int k = 0;
        int ncyc = 0;
        bit fin = 0;
        start = 1; mode = 1; step(); start = 0;
        while (ncyc < 300 && !fin) begin
            if (done) begin
                chk("load_final_we", {26'd0, rf_we, rf_waddr}, {26'd0, 1'b1, 5'd31});
                fin = 1;
            end else if (stop_after > 0 && k == stop_after) begin
                fin = 1;
            end else begin
                chk("load_in_ready", {31'd0, in_ready}, 32'd1);
                in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = base + k;
                if (in_valid) k++;
                step();
                ncyc++;
            end
        end
        in_valid = 0;
        if (!fin) chk("load_timeout", 32'd0, 32'd1);
        if (stop_after == 0) begin
            chk("load_count", k, 32'd32);
            step();
            chk("load_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    typedef struct {
        logic start;
        logic mode;
        logic abort;
        logic exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int hs;
        bit ok;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, c_load_en};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 0; preload = 1; start = 0; mode = 0; abort = 0;
        out_ready = 0; in_valid = 0; in_data = '0;
        repeat (3) step();
        chk("rst_ctrl", {26'd0, busy, done, rf_we, out_valid, out_last, in_ready}, 32'd0);
        chk("rst_addr", {22'd0, rf_raddr, rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_odata", out_data, 32'd0);
        preload = 0; rst_n = 1;
        step();

        for (int i = 0; i < 6; i++) begin
            start = vecs[i].start; mode = vecs[i].mode; abort = vecs[i].abort;
            step();
            start = 0; abort = 0;
            chk("vec_busy", {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            chk("vec_done", {31'd0, done}, 32'd0);
            if (busy) begin
                abort = 1; step(); abort = 0;
            end
        end

        run_dump(1'b0, 32'h1000_0000);
        run_dump(1'b1, 32'h1000_0000);

        hs = 0; ok = 0;
        start = 1; mode = 0; step(); start = 0;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (out_valid && hs == 5) begin
                ok = 1;
            end else begin
                out_ready = 1;
                if (out_valid) hs++;
                step();
            end
        end
        out_ready = 0;
        if (!ok) chk("abort_reach_timeout", 32'd0, 32'd1);
        chk("abort_word5", out_data, 32'h1000_0005);
        abort = 1; step(); abort = 0;
        chk("abort_state", {29'd0, busy, out_valid, out_last}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk("abort_no_done", {31'd0, done}, 32'd0);
            step();
        end
        run_dump(1'b0, 32'h1000_0000);

`ifdef REGFILE_XFER_LOAD_EN
        run_load(32'hA5A5_0000, 1'b1, 0);
        run_dump(1'b0, 32'hA5A5_0000);
        run_load(32'h5A5A_0000, 1'b0, 10);
        step();
        #1 rst_n = 0;
        #1;
        chk("rst_mid_ctrl", {26'd0, busy, done, rf_we, out_valid, out_last, in_ready}, 32'd0);
        chk("rst_mid_wdata", rf_wdata, 32'd0);
        step(); step();
        rst_n = 1;
        step();
        for (int r = 1; r < 10; r++) chk("rst_mid_kept", regs[r], 32'h5A5A_0000 + r);
        chk("rst_mid_x10", regs[10], 32'hA5A5_000A);
`else
        start = 1; mode = 1; step(); start = 0;
        for (int c = 0; c < 40; c++) begin
            chk("noload_quiet", {29'd0, busy, in_ready, done}, 32'd0);
            step();
        end
        run_dump(1'b0, 32'h1000_0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
